ppi_bus_sequencer: RTL and testbench
====================================

# ppi_bus_sequencer

Clocked bus master that sequences Intel 8255 PPI (`ppi_8255`) read/write cycles on behalf of two on-chip requesters. It arbitrates round-robin between requester 0 and requester 1, generates the PPI strobes with programmable setup/strobe/hold timing, and returns read data or a completion pulse. It sits between the system-side logic and the `ppi_8255` D/A_in/cs/read/write pins. The top level owns the D tristate.

## Interface
- `SETUP_CYCLES`, default 1: cycles cs/A/D are valid before the strobe; range 1..15.
- `STROBE_CYCLES`, default 2: cycles read or write is high; range 1..15.
- `HOLD_CYCLES`, default 1: cycles cs/A/D are held after the strobe; range 1..15.
- `clk`  in  1  single system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid & ready.
- `req0_rw` / `req1_rw`  in  1  1 = read, 0 = write.
- `req0_addr` / `req1_addr`  in  2  PPI address: 00 PA, 01 PB, 10 PC, 11 control.
- `req0_wdata` / `req1_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_err`  out  1  request was illegal and no bus cycle was run.
- `rsp_rdata`  out  8  read data; 0 for writes and errors.
- `busy`  out  1  state is not IDLE.
- `ppi_cs`  out  1  PPI chip select, active-low.
- `ppi_read` / `ppi_write`  out  1  PPI strobes, active-high.
- `ppi_a`  out  2  drives PPI `A_in`.
- `ppi_d_out`  out  8  write data.
- `ppi_d_oe`  out  1  D drive enable.
- `ppi_d_in`  in  8  D bus readback.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, ERR.
- IDLE:
  - The arbiter grants one valid requester. `reqN_ready` = IDLE & grant==N, and may depend combinationally on the valids.
  - On handshake, capture rw, addr, wdata and id.
  - A read to addr 11 goes to ERR. Any other request goes to SETUP.
- SETUP: cs=0, A=addr, and d_oe=1 with d_out=wdata for writes only. Stay SETUP_CYCLES cycles.
- STROBE: same as SETUP plus read=1 (read) or write=1 (write). Stay STROBE_CYCLES cycles. Reads sample `ppi_d_in` into the rdata register on the clock edge that ends the last STROBE cycle.
- HOLD: strobes are 0; cs, A and D are unchanged. Stay HOLD_CYCLES cycles, then go to IDLE.
- ERR: lasts one cycle, no bus activity, then go to IDLE.
- Response: rsp_valid=1 for exactly the first IDLE cycle after HOLD or ERR, with rsp_id equal to the captured id. rsp_err=1 only after ERR. rsp_rdata is the sampled value for reads and 0 otherwise.
- Arbitration:
  - `last_grant` register. If both requesters are valid, the one not equal to `last_grant` wins. If only one is valid, it wins.
  - `last_grant` updates on every handshake.
- read and write are never high together. cs is high in IDLE and ERR.

## Timing
- All PPI-side outputs and rsp_* are registered or decoded from registered state. There is no combinational path from req* to the PPI pins.
- Handshake in cycle T0 gives:
  - SETUP in T1..T(S), STROBE for the next W cycles, HOLD for the next H cycles.
  - rsp_valid in cycle T(S+W+H+1).
- A new handshake may occur in the same cycle as rsp_valid. Sustained throughput is one transaction per 1+S+W+H cycles.
- Error path: handshake in T0, ERR in T1, rsp_valid in T2.
- Reset values: ppi_cs=1, ppi_read=0, ppi_write=0, ppi_a=00, ppi_d_out=00, ppi_d_oe=0, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_rdata=00, busy=0, reqN_ready=0, state=IDLE, last_grant=1 (requester 0 wins first).
- Reset asserted mid-transaction:
  - All outputs take their reset values immediately, without waiting for a clock.
  - The transaction is dropped and no response is issued.
- Timer: one 4-bit down-counter, loaded with (N-1) on state entry.

## Structure
- Shared package `ppi_pkg`:
  - state enum `ppi_seq_state_t`.
  - address constants `PPI_ADDR_PA/PB/PC/CTRL`.
  - `PPI_RW_READ = 1'b1`.
- Sub-module `ppi_rr_arbiter`: 2-way round-robin arbiter. Inputs: valids, `last_grant`, enable. Outputs: one-hot grant.
- The FSM, timer and capture registers stay in `ppi_bus_sequencer`.

## Test plan
- **Write.** Defaults (1/2/1), req0 writes addr 11, data 80 at T0.
  - cs=0 in T1..T4, write=1 in T2..T3 only, A=11, d_oe=1, d_out=80 throughout.
  - rsp_valid, id=0, err=0 in T5.
- **Read.** req1 reads addr 00 with ppi_d_in=F0; ppi_d_in changes to 0F one cycle after STROBE ends.
  - read=1 for 2 cycles, d_oe=0.
  - rsp_rdata=F0, rsp_id=1 in T5.
- **Arbitration.** Both requesters continuously valid for 4 transactions → grant order 0,1,0,1. Also check that ready is never high for both in the same cycle.
- **Illegal read.** req0 reads addr 11 → cs never low, rsp_valid in T2 with rsp_err=1 and rdata=00.
- **Reset mid-transfer.** Assert reset in the middle of the STROBE of a write → write=0, cs=1, d_oe=0 before the next clock edge, no rsp_valid. After reset, a request from req0 is granted first.
- **Parameter corner.** SETUP=HOLD=STROBE=15 → write high exactly 15 cycles, rsp_valid exactly 46 cycles after the handshake.

Source files
------------

// File: rtl/ppi_pkg.sv
// ppi_pkg
// Shared types and constants for the 8255 PPI bus sequencer:
//   ppi_seq_state_t - sequencer FSM states
//   PPI_ADDR_*      - 8255 register addresses on A_in
//   PPI_RW_READ     - encoding of a read request on reqN_rw
//   ppi_is_illegal  - flags requests that must not reach the bus
package ppi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ERR    = 3'd4
    } ppi_seq_state_t;

    localparam logic [1:0] PPI_ADDR_PA   = 2'b00;
    localparam logic [1:0] PPI_ADDR_PB   = 2'b01;
    localparam logic [1:0] PPI_ADDR_PC   = 2'b10;
    localparam logic [1:0] PPI_ADDR_CTRL = 2'b11;

    localparam logic PPI_RW_READ = 1'b1;

    // The 8255 control word register is write-only, so reading it is
    // rejected without running a bus cycle.
    function automatic logic ppi_is_illegal(input logic rw, input logic [1:0] addr);
        return (rw == PPI_RW_READ) && (addr == PPI_ADDR_CTRL);
    endfunction

endpackage

// File: rtl/ppi_bus_sequencer_if.sv
// ppi_bus_sequencer_if
// Bundles the requester handshakes, the response channel and the 8255 pins.
//   master : view of the sequencer (drives ready, rsp_*, busy, ppi_* pins)
//   slave  : view of the requesters / PPI side (drives valid, rw, addr,
//            wdata and the D readback)
interface ppi_bus_sequencer_if;

    logic       req0_valid;
    logic       req0_ready;
    logic       req0_rw;
    logic [1:0] req0_addr;
    logic [7:0] req0_wdata;

    logic       req1_valid;
    logic       req1_ready;
    logic       req1_rw;
    logic [1:0] req1_addr;
    logic [7:0] req1_wdata;

    logic       rsp_valid;
    logic       rsp_id;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic       busy;

    logic       ppi_cs;
    logic       ppi_read;
    logic       ppi_write;
    logic [1:0] ppi_a;
    logic [7:0] ppi_d_out;
    logic       ppi_d_oe;
    logic [7:0] ppi_d_in;

    modport master (
        input  req0_valid, req0_rw, req0_addr, req0_wdata,
        input  req1_valid, req1_rw, req1_addr, req1_wdata,
        input  ppi_d_in,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_err, rsp_rdata, busy,
        output ppi_cs, ppi_read, ppi_write, ppi_a, ppi_d_out, ppi_d_oe
    );

    modport slave (
        output req0_valid, req0_rw, req0_addr, req0_wdata,
        output req1_valid, req1_rw, req1_addr, req1_wdata,
        output ppi_d_in,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_err, rsp_rdata, busy,
        input  ppi_cs, ppi_read, ppi_write, ppi_a, ppi_d_out, ppi_d_oe
    );

endinterface

// File: rtl/ppi_rr_arbiter.sv
// ppi_rr_arbiter
// Two-way round-robin arbiter.
//   valid      : request pending per requester (bit N = requester N)
//   last_grant : requester that won the previous handshake
//   enable     : grants are only issued while enabled
//   grant      : one-hot grant, already qualified by valid
module ppi_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // With both requesting, the one that did not win last time goes next;
    // a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// ppi_bus_sequencer
// Bus master that runs 8255 PPI read/write cycles for two requesters with
// programmable setup/strobe/hold timing.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : requester handshakes, response channel and PPI pins
//           (see ppi_bus_sequencer_if)
// Parameters SETUP_CYCLES / STROBE_CYCLES / HOLD_CYCLES: 1..15 each.
module ppi_bus_sequencer
    import ppi_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                clk,
    input  logic                reset,
    ppi_bus_sequencer_if.master bus
);

    // The timer counts down to zero, so each phase loads its length minus one.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    ppi_seq_state_t state_q, state_d;
    logic [3:0]     timer_q, timer_d;
    logic           rw_q, rw_d;
    logic [1:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           id_q, id_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           last_grant_q, last_grant_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;

    logic [1:0]     grant;
    logic           arb_enable;
    logic           handshake;
    logic           sel_rw;
    logic [1:0]     sel_addr;
    logic [7:0]     sel_wdata;
    logic           timer_done;
    logic           bus_active;
    logic           drive_data;

    // Reset gates the enable so ready drops the moment reset rises even
    // while a requester holds valid.
    assign arb_enable = (state_q == IDLE) && !reset;

    ppi_rr_arbiter u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_q),
        .enable     (arb_enable),
        .grant      (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign handshake      = grant[0] | grant[1];

    assign sel_rw    = grant[1] ? bus.req1_rw    : bus.req0_rw;
    assign sel_addr  = grant[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant[1] ? bus.req1_wdata : bus.req0_wdata;

    assign timer_done = (timer_q == 4'd0);

    // Next-state logic: capture on handshake, walk SETUP -> STROBE -> HOLD
    // on the shared down-counter, and schedule the one-cycle response for
    // the first IDLE cycle afterwards.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        id_d         = id_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    rw_d         = sel_rw;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    rdata_d      = 8'h00;
                    if (ppi_is_illegal(sel_rw, sel_addr)) begin
                        state_d = ERR;
                    end else begin
                        state_d = SETUP;
                        timer_d = SETUP_LOAD;
                    end
                end
            end
            SETUP: begin
                if (timer_done) begin
                    state_d = STROBE;
                    timer_d = STROBE_LOAD;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            STROBE: begin
                if (timer_done) begin
                    // Read data is taken on the edge that ends the strobe.
                    if (rw_q == PPI_RW_READ) begin
                        rdata_d = bus.ppi_d_in;
                    end
                    state_d = HOLD;
                    timer_d = HOLD_LOAD;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            HOLD: begin
                if (timer_done) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ERR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers. last_grant resets to 1 so requester 0
    // wins the first contested arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= 4'd0;
            rw_q         <= 1'b0;
            addr_q       <= 2'b00;
            wdata_q      <= 8'h00;
            id_q         <= 1'b0;
            rdata_q      <= 8'h00;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            id_q         <= id_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // PPI pins decode purely from registered state, so a reset clears them
    // immediately and no requester input reaches them combinationally.
    assign bus_active = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign drive_data = bus_active && (rw_q != PPI_RW_READ);

    assign bus.ppi_cs    = !bus_active;
    assign bus.ppi_read  = (state_q == STROBE) && (rw_q == PPI_RW_READ);
    assign bus.ppi_write = (state_q == STROBE) && (rw_q != PPI_RW_READ);
    assign bus.ppi_a     = bus_active ? addr_q : 2'b00;
    assign bus.ppi_d_oe  = drive_data;
    assign bus.ppi_d_out = drive_data ? wdata_q : 8'h00;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_valid_q ? rdata_q : 8'h00;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// tb_ppi_bus_sequencer
// Self-checking bench for ppi_bus_sequencer. A default-timing instance is
// tracked every cycle by a transaction-level model; a second instance with
// 15/15/15 timing covers the long-timing corner.
module tb_ppi_bus_sequencer;

    localparam int S = 1;
    localparam int W = 2;
    localparam int H = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    ppi_bus_sequencer_if bus ();
    ppi_bus_sequencer_if bus2 ();

    ppi_bus_sequencer #(
        .SETUP_CYCLES  (S),
        .STROBE_CYCLES (W),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ppi_bus_sequencer #(
        .SETUP_CYCLES  (15),
        .STROBE_CYCLES (15),
        .HOLD_CYCLES   (15)
    ) dut_slow (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drives one requester of the default-timing instance.
    task automatic applyStimulus(input bit port, input bit valid, input bit rw,
                                 input logic [1:0] addr, input logic [7:0] wdata);
        if (port == 1'b0) begin
            bus.req0_valid = valid;
            bus.req0_rw    = rw;
            bus.req0_addr  = addr;
            bus.req0_wdata = wdata;
        end else begin
            bus.req1_valid = valid;
            bus.req1_rw    = rw;
            bus.req1_addr  = addr;
            bus.req1_wdata = wdata;
        end
    endtask

    // Transaction model: an accepted request occupies cycles 1..S+W+H after
    // its handshake (setup, then strobe, then hold); an illegal read occupies
    // one cycle. The response shows in the first cycle after that window.
    bit         m_active  = 1'b0;
    int         m_k       = 0;
    bit         m_id      = 1'b0;
    bit         m_rw      = 1'b0;
    bit         m_err     = 1'b0;
    logic [1:0] m_addr    = 2'b00;
    logic [7:0] m_wdata   = 8'h00;
    logic [7:0] m_rsample = 8'h00;
    bit         m_rsp_due = 1'b0;
    bit         m_last    = 1'b1;
    bit         m_bus_on;
    bit         m_strobe_on;
    bit         m_r0;
    bit         m_r1;
    int         m_len;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_active  = 1'b0;
                m_k       = 0;
                m_rsp_due = 1'b0;
                m_last    = 1'b1;
            end
            m_len       = m_err ? 1 : S + W + H;
            m_bus_on    = m_active && !m_err;
            m_strobe_on = m_bus_on && (m_k > S) && (m_k <= S + W);
            m_r0 = !reset && !m_active && bus.req0_valid && (!bus.req1_valid || m_last);
            m_r1 = !reset && !m_active && bus.req1_valid && (!bus.req0_valid || !m_last);

            checkOutput("m_cs",        32'(bus.ppi_cs),    32'(!m_bus_on));
            checkOutput("m_read",      32'(bus.ppi_read),  32'(m_strobe_on && m_rw));
            checkOutput("m_write",     32'(bus.ppi_write), 32'(m_strobe_on && !m_rw));
            checkOutput("m_a",         32'(bus.ppi_a),     32'(m_bus_on ? m_addr : 2'b00));
            checkOutput("m_d_oe",      32'(bus.ppi_d_oe),  32'(m_bus_on && !m_rw));
            checkOutput("m_d_out",     32'(bus.ppi_d_out), 32'((m_bus_on && !m_rw) ? m_wdata : 8'h00));
            checkOutput("m_busy",      32'(bus.busy),      32'(m_active));
            checkOutput("m_ready0",    32'(bus.req0_ready), 32'(m_r0));
            checkOutput("m_ready1",    32'(bus.req1_ready), 32'(m_r1));
            checkOutput("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_due));
            if (m_rsp_due) begin
                checkOutput("m_rsp_id",    32'(bus.rsp_id),    32'(m_id));
                checkOutput("m_rsp_err",   32'(bus.rsp_err),   32'(m_err));
                checkOutput("m_rsp_rdata", 32'(bus.rsp_rdata),
                            32'((m_err || !m_rw) ? 8'h00 : m_rsample));
            end

            if (!reset) begin
                if (m_active) begin
                    if (m_strobe_on && (m_k == S + W) && m_rw) begin
                        m_rsample = bus.ppi_d_in;
                    end
                    if (m_k == m_len) begin
                        m_active  = 1'b0;
                        m_rsp_due = 1'b1;
                    end else begin
                        m_k++;
                    end
                end else begin
                    m_rsp_due = 1'b0;
                    if (m_r0 || m_r1) begin
                        m_active = 1'b1;
                        m_k      = 1;
                        m_id     = m_r1;
                        m_last   = m_r1;
                        m_rw     = m_r1 ? bus.req1_rw    : bus.req0_rw;
                        m_addr   = m_r1 ? bus.req1_addr  : bus.req0_addr;
                        m_wdata  = m_r1 ? bus.req1_wdata : bus.req0_wdata;
                        m_err    = m_rw && (m_addr == 2'b11);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int grants[4];
    int ngr;
    int wr_cnt;
    int cs_cnt;
    int lat;

    // Directed scenarios with hand-computed expectations.
    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        bus.ppi_d_in     = 8'h00;
        bus2.req0_valid  = 1'b0;
        bus2.req0_rw     = 1'b0;
        bus2.req0_addr   = 2'b00;
        bus2.req0_wdata  = 8'h00;
        bus2.req1_valid  = 1'b0;
        bus2.req1_rw     = 1'b0;
        bus2.req1_addr   = 2'b00;
        bus2.req1_wdata  = 8'h00;
        bus2.ppi_d_in    = 8'h00;
        reset            = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cs",        32'(bus.ppi_cs),     32'd1);
        checkOutput("rst_read",      32'(bus.ppi_read),   32'd0);
        checkOutput("rst_write",     32'(bus.ppi_write),  32'd0);
        checkOutput("rst_a",         32'(bus.ppi_a),      32'd0);
        checkOutput("rst_d_out",     32'(bus.ppi_d_out),  32'd0);
        checkOutput("rst_d_oe",      32'(bus.ppi_d_oe),   32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        checkOutput("rst_rsp_id",    32'(bus.rsp_id),     32'd0);
        checkOutput("rst_rsp_err",   32'(bus.rsp_err),    32'd0);
        checkOutput("rst_rsp_rdata", 32'(bus.rsp_rdata),  32'd0);
        checkOutput("rst_busy",      32'(bus.busy),       32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Write: req0 writes 0x80 to the control register.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 8'h80);
        @(negedge clk);
        checkOutput("wr_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            checkOutput("wr_cs",        32'(bus.ppi_cs),    32'(t > 4));
            checkOutput("wr_write",     32'(bus.ppi_write), 32'(t == 2 || t == 3));
            checkOutput("wr_rsp_valid", 32'(bus.rsp_valid), 32'(t == 5));
            if (t <= 4) begin
                checkOutput("wr_a",     32'(bus.ppi_a),     32'd3);
                checkOutput("wr_d_oe",  32'(bus.ppi_d_oe),  32'd1);
                checkOutput("wr_d_out", 32'(bus.ppi_d_out), 32'h80);
            end else begin
                checkOutput("wr_rsp_id",  32'(bus.rsp_id),  32'd0);
                checkOutput("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
            end
        end
        @(posedge clk); #1;

        // Read: req1 reads PA; D changes after the strobe has ended.
        bus.ppi_d_in = 8'hF0;
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 8'h00);
        @(negedge clk);
        checkOutput("rd_ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            checkOutput("rd_read", 32'(bus.ppi_read), 32'(t == 2 || t == 3));
            checkOutput("rd_d_oe", 32'(bus.ppi_d_oe), 32'd0);
            if (t == 5) begin
                checkOutput("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                checkOutput("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hF0);
                checkOutput("rd_rsp_id",    32'(bus.rsp_id),    32'd1);
            end
            if (t == 3) begin
                @(posedge clk); #1;
                bus.ppi_d_in = 8'h0F;
            end
        end
        @(posedge clk); #1;

        // Arbitration: both requesters continuously valid.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 8'hA5);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 8'h5A);
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 4; c++) begin
            @(negedge clk);
            checkOutput("arb_both_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.req0_ready) begin
                grants[ngr] = 0;
                ngr++;
            end else if (bus.req1_ready) begin
                grants[ngr] = 1;
                ngr++;
            end
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        checkOutput("arb_grant_count", 32'(ngr), 32'd4);
        if (ngr > 0) checkOutput("arb_order0", 32'(grants[0]), 32'd0);
        if (ngr > 1) checkOutput("arb_order1", 32'(grants[1]), 32'd1);
        if (ngr > 2) checkOutput("arb_order2", 32'(grants[2]), 32'd0);
        if (ngr > 3) checkOutput("arb_order3", 32'(grants[3]), 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // Illegal read of the control register.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 8'h00);
        @(negedge clk);
        checkOutput("err_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        checkOutput("err_t1_cs",        32'(bus.ppi_cs),    32'd1);
        checkOutput("err_t1_busy",      32'(bus.busy),      32'd1);
        checkOutput("err_t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("err_t2_cs",        32'(bus.ppi_cs),    32'd1);
        checkOutput("err_t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("err_t2_rsp_err",   32'(bus.rsp_err),   32'd1);
        checkOutput("err_t2_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a write strobe.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 8'h55);
        @(negedge clk);
        checkOutput("rm_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rm_write_before", 32'(bus.ppi_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rm_write", 32'(bus.ppi_write), 32'd0);
        checkOutput("rm_cs",    32'(bus.ppi_cs),    32'd1);
        checkOutput("rm_d_oe",  32'(bus.ppi_d_oe),  32'd0);
        checkOutput("rm_busy",  32'(bus.busy),      32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 8'h66);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 8'h77);
        @(posedge clk); #1;
        checkOutput("rm_ready0_in_reset", 32'(bus.req0_ready), 32'd0);
        checkOutput("rm_ready1_in_reset", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("rm_ready0_after", 32'(bus.req0_ready), 32'd1);
        checkOutput("rm_ready1_after", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        repeat (6) @(posedge clk);
        #1;

        // Long-timing corner on the 15/15/15 instance.
        bus2.req0_rw    = 1'b0;
        bus2.req0_addr  = 2'b10;
        bus2.req0_wdata = 8'h3C;
        bus2.req0_valid = 1'b1;
        @(negedge clk);
        checkOutput("slow_ready0", 32'(bus2.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus2.req0_valid = 1'b0;
        wr_cnt = 0;
        cs_cnt = 0;
        lat    = 0;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (bus2.ppi_write) wr_cnt++;
            if (!bus2.ppi_cs) cs_cnt++;
            if (bus2.rsp_valid && lat == 0) lat = t;
        end
        checkOutput("slow_write_cycles", 32'(wr_cnt), 32'd15);
        checkOutput("slow_cs_cycles",    32'(cs_cnt), 32'd45);
        checkOutput("slow_rsp_latency",  32'(lat),    32'd46);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
